// File: rtl/datamover_tcdm_arbiter.sv
// datamover_tcdm_arbiter: round-robin merge of NB_LD load and NB_ST store HCI channels onto one
// TCDM master port. A tag FIFO routes in-order read responses back to the issuing load channel.
// Latency: request and response paths are 0-cycle combinational; tag FIFO updates on the next edge.
// Backpressure: grant follows out_gnt_i; loads stall while the tag FIFO is full; enable_i low blocks grants.
// Option: define DATAMOVER_TCDM_ARB_ORPHAN_CNT_EN to add orphan_cnt_o, a saturating count of dropped responses.
module datamover_tcdm_arbiter #(
  parameter int NB_LD     = 2,
  parameter int NB_ST     = 1,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       enable_i,
  input  logic [NB_LD-1:0]           ld_req_i,
  output logic [NB_LD-1:0]           ld_gnt_o,
  input  logic [NB_LD*AW-1:0]        ld_add_i,
  output logic [NB_LD-1:0]           ld_r_valid_o,
  output logic [DW-1:0]              ld_r_data_o,
  input  logic [NB_ST-1:0]           st_req_i,
  output logic [NB_ST-1:0]           st_gnt_o,
  input  logic [NB_ST*AW-1:0]        st_add_i,
  input  logic [NB_ST*DW-1:0]        st_data_i,
  input  logic [NB_ST*DW/8-1:0]      st_be_i,
  output logic                       out_req_o,
  output logic [AW-1:0]              out_add_o,
  output logic                       out_wen_o,
  output logic [DW-1:0]              out_data_o,
  output logic [DW/8-1:0]            out_be_o,
  input  logic                       out_gnt_i,
  input  logic                       out_r_valid_i,
  input  logic [DW-1:0]              out_r_data_i,
  output logic [$clog2(MAX_OUTST):0] outst_cnt_o,
  output logic                       idle_o
`ifdef DATAMOVER_TCDM_ARB_ORPHAN_CNT_EN
  ,
  output logic [15:0]                orphan_cnt_o
`endif
);

  localparam int NCH = NB_LD + NB_ST;
  localparam int CW  = $clog2(NCH);
  localparam int LW  = (NB_LD > 1) ? $clog2(NB_LD) : 1;
  localparam int PW  = $clog2(MAX_OUTST);
  localparam int BW  = DW / 8;

  // Round-robin pointer and tag FIFO state
  logic [CW-1:0] r_ptr;
  logic [LW-1:0] r_tag [MAX_OUTST];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_cnt;
  logic          r_full;
  logic          r_empty;

  logic [NCH-1:0] w_elig;
  logic           w_any;
  logic [CW-1:0]  w_sel;
  logic           w_sel_ld;
  logic           w_hs;
  logic           w_push;
  logic           w_pop;
  logic [LW-1:0]  w_head;
  logic [PW:0]    w_cnt_nxt;
  logic [CW-1:0]  w_ptr_nxt;

  // Eligibility: request and enable; loads also need a free tag slot
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NB_LD; i++) w_elig[i] = ld_req_i[i] & enable_i & ~r_full;
    for (int j = 0; j < NB_ST; j++) w_elig[NB_LD+j] = st_req_i[j] & enable_i;
  end

  // Round-robin search: first eligible channel at or after r_ptr, wrapping
  always_comb begin
    logic [CW:0] w_c;
    w_any = 1'b0;
    w_sel = '0;
    w_c   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_c = {1'b0, r_ptr} + (CW+1)'(k);
      if (w_c >= (CW+1)'(NCH)) w_c = w_c - (CW+1)'(NCH);
      if (!w_any && w_elig[w_c[CW-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_c[CW-1:0];
      end
    end
  end

  // Drive the master port from the selected channel and return its grant
  always_comb begin
    out_add_o  = '0;
    out_wen_o  = 1'b0;
    out_data_o = '0;
    out_be_o   = '0;
    ld_gnt_o   = '0;
    st_gnt_o   = '0;
    w_sel_ld   = 1'b0;
    for (int i = 0; i < NB_LD; i++) begin
      if (w_any && (w_sel == CW'(i))) begin
        out_add_o   = ld_add_i[i*AW +: AW];
        out_wen_o   = 1'b1;
        out_be_o    = '1;
        ld_gnt_o[i] = out_gnt_i;
        w_sel_ld    = 1'b1;
      end
    end
    for (int j = 0; j < NB_ST; j++) begin
      if (w_any && (w_sel == CW'(NB_LD + j))) begin
        out_add_o   = st_add_i[j*AW +: AW];
        out_data_o  = st_data_i[j*DW +: DW];
        out_be_o    = st_be_i[j*BW +: BW];
        st_gnt_o[j] = out_gnt_i;
      end
    end
  end

  assign out_req_o = w_any;
  assign w_hs      = w_any & out_gnt_i;
  // clear_i wins over both FIFO operations; a response in a clear cycle is dropped
  assign w_push    = w_hs & w_sel_ld & ~clear_i;
  assign w_pop     = out_r_valid_i & ~r_empty & ~clear_i;
  assign w_head    = r_tag[r_rptr];
  assign w_ptr_nxt = (w_sel == CW'(NCH - 1)) ? '0 : w_sel + 1'b1;

  // Response routing: head tag selects the load channel that sees the valid strobe
  always_comb begin
    ld_r_valid_o = '0;
    for (int i = 0; i < NB_LD; i++) ld_r_valid_o[i] = w_pop & (w_head == LW'(i));
  end

  assign ld_r_data_o = w_pop ? out_r_data_i : '0;

  // Next occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Pointer, FIFO indices and registered full/empty flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else if (clear_i) begin
      r_ptr   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_hs)   r_ptr  <= w_ptr_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == (PW+1)'(MAX_OUTST));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  // Tag storage: the issuing load channel index of each outstanding read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTST; i++) r_tag[i] <= '0;
    end else if (w_push) begin
      r_tag[r_wptr] <= LW'(w_sel);
    end
  end

  assign outst_cnt_o = r_cnt;
  // Idle means nothing in flight and no channel currently requesting
  assign idle_o      = r_empty & ~(|ld_req_i) & ~(|st_req_i);

`ifdef DATAMOVER_TCDM_ARB_ORPHAN_CNT_EN
  logic        w_drop;
  logic [15:0] r_orph;

  assign w_drop = out_r_valid_i & ~w_pop;

  // Saturating count of responses that found no outstanding tag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_orph <= '0;
    end else if (clear_i) begin
      r_orph <= '0;
    end else if (w_drop && (r_orph != 16'hFFFF)) begin
      r_orph <= r_orph + 16'd1;
    end
  end

  assign orphan_cnt_o = r_orph;
`endif

endmodule

// File: tb/tb_datamover_tcdm_arbiter.sv
// Testbench for datamover_tcdm_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based reference model of arbitration and tag routing.
`timescale 1ns/1ps
module tb_datamover_tcdm_arbiter;
  localparam int NB_LD = 2, NB_ST = 1, DW = 32, AW = 32, MAX_OUTST = 4;
  localparam int NCH = NB_LD + NB_ST, BW = DW / 8;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, en = 1'b0;
  logic [NB_LD-1:0] ld_req = '0, ld_gnt, ld_rv;
  logic [NB_ST-1:0] st_req = '0, st_gnt;
  logic [AW-1:0] la [NB_LD];
  logic [AW-1:0] sa [NB_ST];
  logic [DW-1:0] sd [NB_ST];
  logic [BW-1:0] sb [NB_ST];
  logic [NB_LD*AW-1:0] ld_add_w;
  logic [NB_ST*AW-1:0] st_add_w;
  logic [NB_ST*DW-1:0] st_dat_w;
  logic [NB_ST*BW-1:0] st_be_w;
  logic [DW-1:0] ld_rdata, out_data, rdata = '0;
  logic [AW-1:0] out_add;
  logic [BW-1:0] out_be;
  logic out_req, out_wen, ogn = 1'b0, rv = 1'b0, idle;
  logic [$clog2(MAX_OUTST):0] outst;
`ifdef DATAMOVER_TCDM_ARB_ORPHAN_CNT_EN
  logic [15:0] orph;
`endif

  int errors = 0, checks = 0;
  int m_ptr = 0, m_orph = 0, m_gsel = -1;
  int m_q[$];
  int obs_g;
  logic obs_req;
  logic [NB_LD-1:0] obs_rv;
  logic [DW-1:0] obs_rd;

  always_comb begin
    for (int i = 0; i < NB_LD; i++) ld_add_w[i*AW +: AW] = la[i];
    for (int j = 0; j < NB_ST; j++) begin
      st_add_w[j*AW +: AW] = sa[j];
      st_dat_w[j*DW +: DW] = sd[j];
      st_be_w[j*BW +: BW]  = sb[j];
    end
  end

  always #5 clk = ~clk;

  datamover_tcdm_arbiter #(.NB_LD(NB_LD), .NB_ST(NB_ST), .DW(DW), .AW(AW), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .enable_i(en),
    .ld_req_i(ld_req), .ld_gnt_o(ld_gnt), .ld_add_i(ld_add_w),
    .ld_r_valid_o(ld_rv), .ld_r_data_o(ld_rdata),
    .st_req_i(st_req), .st_gnt_o(st_gnt), .st_add_i(st_add_w), .st_data_i(st_dat_w), .st_be_i(st_be_w),
    .out_req_o(out_req), .out_add_o(out_add), .out_wen_o(out_wen), .out_data_o(out_data), .out_be_o(out_be),
    .out_gnt_i(ogn), .out_r_valid_i(rv), .out_r_data_i(rdata),
    .outst_cnt_o(outst), .idle_o(idle)
`ifdef DATAMOVER_TCDM_ARB_ORPHAN_CNT_EN
    , .orphan_cnt_o(orph)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One cycle: called at posedge+1 with inputs set; checks mid-cycle, advances the model at the edge
  task automatic step();
    int sel, j;
    logic [NCH-1:0] req_all, gv, exp_g;
    logic [NB_LD-1:0] exp_rv;
    logic pop;
    #3;
    req_all = {st_req, ld_req};
    sel = -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (sel < 0 && req_all[c] && en && (c >= NB_LD || m_q.size() < MAX_OUTST)) sel = c;
    end
    gv = {st_gnt, ld_gnt};
    obs_g = -1;
    for (int k = 0; k < NCH; k++) if (gv[k]) obs_g = k;
    obs_req = out_req; obs_rv = ld_rv; obs_rd = ld_rdata;
    exp_g = '0;
    if (sel >= 0 && ogn) exp_g[sel] = 1'b1;
    check("out_req", out_req, sel >= 0);
    check("gnt", gv, exp_g);
    if (sel >= 0 && sel < NB_LD) begin
      check("ld_add", out_add, la[sel]);
      check("ld_wen", out_wen, 1);
      check("ld_be", out_be, {BW{1'b1}});
      check("ld_data", out_data, 0);
    end else if (sel >= NB_LD) begin
      j = sel - NB_LD;
      check("st_add", out_add, sa[j]);
      check("st_wen", out_wen, 0);
      check("st_be", out_be, sb[j]);
      check("st_data", out_data, sd[j]);
    end
    pop = rv && !clr && (m_q.size() > 0);
    exp_rv = '0;
    if (pop) exp_rv[m_q[0]] = 1'b1;
    check("r_valid", ld_rv, exp_rv);
    check("r_data", ld_rdata, pop ? rdata : '0);
    check("outst", outst, m_q.size());
    check("idle", idle, (m_q.size() == 0) && (req_all == '0));
`ifdef DATAMOVER_TCDM_ARB_ORPHAN_CNT_EN
    check("orphan", orph, m_orph);
`endif
    if (clr) begin
      m_q.delete(); m_ptr = 0; m_orph = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      else if (rv && m_orph < 65535) m_orph++;
      if (sel >= 0 && ogn) begin
        m_ptr = (sel + 1) % NCH;
        if (sel < NB_LD) m_q.push_back(sel);
      end
    end
    m_gsel = (sel >= 0 && ogn) ? sel : -1;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < NB_LD; i++) la[i] = 32'h40 * (i + 1);
    for (int j = 0; j < NB_ST; j++) begin sa[j] = 32'h200; sd[j] = 32'h1234_5678; sb[j] = 4'h5; end
    @(posedge clk); #1;
    check("rst_req", out_req, 0);
    check("rst_outst", outst, 0);
    check("rst_idle", idle, 1);
    check("rst_rv", ld_rv, 0);
    rst_n = 1'b1;
    step();
    en = 1'b1; ogn = 1'b1;

    // Round-robin order with all channels requesting
    ld_req = '1; st_req = '1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_order", obs_g, k % NCH);
      if (k == 2) check("outst_two", outst, 2);
    end
    ld_req = '0; st_req = '0; rv = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rdata = 32'h100 + k;
      step();
      check("drain_cnt", outst, 3 - k);
    end
    rv = 1'b0;

    // Response routing to the issuing load channel
    la[0] = 32'h100; la[1] = 32'h104;
    ld_req = 2'b11; step(); check("route_g0", obs_g, 0);
    ld_req = 2'b10; step(); check("route_g1", obs_g, 1);
    ld_req = 2'b00; rv = 1'b1; rdata = 32'hAAAA; step();
    check("route_v0", obs_rv, 2'b01); check("route_d0", obs_rd, 32'hAAAA);
    rdata = 32'hBBBB; step();
    check("route_v1", obs_rv, 2'b10); check("route_d1", obs_rd, 32'hBBBB);
    rv = 1'b0;

    // Tag FIFO full blocks the fifth load until a response frees a slot
    ld_req = 2'b01;
    for (int k = 0; k < 5; k++) begin
      step();
      check("full_gnt", obs_g, (k < 4) ? 0 : -1);
    end
    check("full_req_blocked", obs_req, 0);
    rv = 1'b1; rdata = 32'h55; step(); check("full_pop_cycle_req", obs_req, 0);
    rv = 1'b0; step(); check("full_regrant", obs_g, 0);
    ld_req = '0; rv = 1'b1;
    repeat (4) step();
    rv = 1'b0;

    // Store then stray response with empty FIFO
    st_req = 1'b1; step(); check("st_gnt", obs_g, 2);
    st_req = 1'b0; rv = 1'b1; rdata = 32'hDEAD; step();
    check("stray_rv", obs_rv, 0);
`ifdef DATAMOVER_TCDM_ARB_ORPHAN_CNT_EN
    check("orphan_one", orph, 1);
`endif
    rv = 1'b0;

    // Clear with three loads outstanding
    ld_req = 2'b01; step(); ld_req = 2'b10; step(); ld_req = 2'b01; step(); ld_req = '0;
    check("pre_clear_cnt", outst, 3);
    clr = 1'b1; step(); clr = 1'b0;
    check("clear_cnt", outst, 0);
    check("clear_idle", idle, 1);
    rv = 1'b1; step(); check("post_clear_rv", obs_rv, 0); rv = 1'b0;

    // Enable gating, then grant from pointer 0
    en = 1'b0; ld_req = '1; st_req = '1; step();
    check("en_off_req", obs_req, 0); check("en_off_gnt", obs_g, -1);
    en = 1'b1; step(); check("en_on_gnt", obs_g, 0);
    ld_req = 2'b10; st_req = '0; step(); ld_req = '0;

    // Reset with two loads outstanding discards tags
    check("pre_rst_cnt", outst, 2);
    rst_n = 1'b0; #2; rst_n = 1'b1;
    m_q.delete(); m_ptr = 0; m_orph = 0;
    check("rst_mid_cnt", outst, 0);
    rv = 1'b1; step(); check("post_rst_rv", obs_rv, 0); rv = 1'b0;

    // Randomized traffic; requesters hold request and payload until granted
    for (int n = 0; n < 3000; n++) begin
      en    = ($urandom_range(0, 9) != 0);
      ogn   = ($urandom_range(0, 9) < 7);
      rv    = ($urandom_range(0, 9) < 4);
      rdata = $urandom;
      clr   = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NB_LD; i++)
        if (!ld_req[i] && $urandom_range(0, 1) == 1) begin ld_req[i] = 1'b1; la[i] = $urandom; end
      for (int j = 0; j < NB_ST; j++)
        if (!st_req[j] && $urandom_range(0, 1) == 1) begin
          st_req[j] = 1'b1; sa[j] = $urandom; sd[j] = $urandom; sb[j] = 4'($urandom);
        end
      step();
      if (m_gsel >= 0 && m_gsel < NB_LD) ld_req[m_gsel] = 1'b0;
      else if (m_gsel >= NB_LD) st_req[m_gsel - NB_LD] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
